apb3_regfile: RTL

APB3 completer-side register file that sits directly downstream of the APB3 master BFM (`uapb3m`) in the APB3 testbench and terminates its transfers. It decodes APB3 setup/access phases, inserts a parameterised number of wait states, and returns `PSLVERR` for unmapped addresses. It maps four registers:

- a read/write control word driven to ports;
- a read-only monitor word sampled from ports;
- a write-1-pulse register;
- a write-transfer counter.

---
 rtl/apb3_regfile.sv | 131 +++++++++++++
 1 files changed

// File: rtl/apb3_regfile.sv
// APB3 completer with four mapped registers: CTRL, STATUS, PULSE and WCOUNT.
// Programmable wait states per access phase; unmapped addresses answer with PSLVERR.
module apb3_regfile #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [15:0]       ctrl_out,
  input  logic [15:0]       mon_in,
  output logic [15:0]       pulse_out
);

  localparam int unsigned IdxW    = ADDR_W - 2;
  localparam logic [2:0]  WaitMax = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e          state_q, state_d;
  logic [2:0]      wcnt_q, wcnt_d;
  logic [15:0]     ctrl_q, ctrl_d;
  logic [15:0]     pulse_q, pulse_d;
  logic [15:0]     mon_meta_q, mon_sync_q;
  logic [31:0]     wcount_q, wcount_d;
  logic [IdxW-1:0] idx;
  logic            addr_ok;
  logic            in_access;
  logic            wr_done;
  logic [31:0]     rdata;
  logic            unused_bits;

  assign idx         = paddr[ADDR_W-1:2];
  assign addr_ok     = (idx <= IdxW'(3));
  assign unused_bits = ^{paddr[1:0], pwdata[31:16]};

  // SETUP marks the cycle after the setup phase was seen, so it already
  // coincides with the first access cycle; ACCESS covers the remaining ones.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    in_access = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (psel && !penable) begin
          state_d = StSetup;
          wcnt_d  = '0;
        end
      end
      StSetup, StAccess: begin
        if (!psel) begin
          state_d = StIdle;
        end else if (!penable) begin
          state_d = StSetup;
          wcnt_d  = '0;
        end else begin
          in_access = 1'b1;
          if (wcnt_q == WaitMax) begin
            state_d = StIdle;
          end else begin
            state_d = StAccess;
            wcnt_d  = wcnt_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pready  = in_access && (wcnt_q == WaitMax);
  assign pslverr = pready && !addr_ok;
  assign wr_done = pready && pwrite;

  always_comb begin
    rdata = '0;
    if (addr_ok) begin
      case (idx[1:0])
        2'd0:    rdata = {16'h0, ctrl_q};
        2'd1:    rdata = {16'h0, mon_sync_q};
        2'd3:    rdata = wcount_q;
        default: rdata = '0;
      endcase
    end
  end

  assign prdata = (pready && !pwrite) ? rdata : '0;

  always_comb begin
    ctrl_d   = ctrl_q;
    pulse_d  = '0;
    wcount_d = wcount_q;
    if (wr_done && addr_ok) begin
      if (idx[1:0] == 2'd0) ctrl_d = pwdata[15:0];
      if (idx[1:0] == 2'd2) pulse_d = pwdata[15:0];
      // A write to WCOUNT clears it instead of counting itself.
      if (idx[1:0] == 2'd3) wcount_d = '0;
      else                  wcount_d = wcount_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wcnt_q     <= '0;
      ctrl_q     <= '0;
      pulse_q    <= '0;
      mon_meta_q <= '0;
      mon_sync_q <= '0;
      wcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      ctrl_q     <= ctrl_d;
      pulse_q    <= pulse_d;
      mon_meta_q <= mon_in;
      mon_sync_q <= mon_meta_q;
      wcount_q   <= wcount_d;
    end
  end

  assign ctrl_out  = ctrl_q;
  assign pulse_out = pulse_q;

endmodule
